// File: rtl/sdram_pkg.sv
// Definitions shared by the SDRAM read and write paths: record tags, types,
// payload lengths and the {ROW, BA, COL} split of a linear address.
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 24;

    localparam logic [3:0] TAG_GEIG = 4'h1;
    localparam logic [3:0] TAG_MAG  = 4'h2;

    localparam logic [2:0] LEN_GEIG = 3'd3;
    localparam logic [2:0] LEN_MAG  = 3'd5;

    typedef enum logic [1:0] {
        REC_NONE = 2'b00,
        REC_GEIG = 2'b01,
        REC_MAG  = 2'b10
    } rec_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_PRESENT
    } rd_state_e;

    // Field order matches the linear layout {ROW[12:0], BA[1:0], COL[8:0]}.
    typedef struct packed {
        logic [12:0] row;
        logic [1:0]  ba;
        logic [8:0]  col;
    } sdram_addr_t;

    function automatic sdram_addr_t split_addr(input logic [SDRAM_ADDR_W-1:0] a);
        return sdram_addr_t'(a);
    endfunction

endpackage

// File: rtl/sdram_record_reader_if.sv
// Bus bundle between the record reader, the SDRAM interface and the
// downlink formatter. master = reader side, slave = everything around it.
interface sdram_record_reader_if;
    import sdram_pkg::*;

    logic [SDRAM_ADDR_W-1:0] WR_ADDR;
    logic                    RD_REQ;
    logic [1:0]              RD_BA;
    logic [8:0]              RD_COL;
    logic [12:0]             RD_ROW;
    logic                    RD_ACK;
    logic [15:0]             RD_DATA;
    logic                    RD_VALID;
    logic [79:0]             REC_DATA;
    logic [1:0]              REC_TYPE;
    logic                    REC_VALID;
    logic                    REC_READY;
    logic [SDRAM_ADDR_W-1:0] RD_PTR;
    logic                    ERR_TAG;
    logic                    ERR_TIMEOUT;

    modport master (
        input  WR_ADDR, RD_ACK, RD_DATA, RD_VALID, REC_READY,
        output RD_REQ, RD_BA, RD_COL, RD_ROW, REC_DATA, REC_TYPE,
        output REC_VALID, RD_PTR, ERR_TAG, ERR_TIMEOUT
    );

    modport slave (
        output WR_ADDR, RD_ACK, RD_DATA, RD_VALID, REC_READY,
        input  RD_REQ, RD_BA, RD_COL, RD_ROW, REC_DATA, REC_TYPE,
        input  REC_VALID, RD_PTR, ERR_TAG, ERR_TIMEOUT
    );

endinterface

// File: rtl/sdram_record_reader_addr_ptr.sv
// Wrapping linear read pointer with the empty compare against the writer
// and the {ROW, BA, COL} field split of the current address.
module sdram_addr_ptr
    import sdram_pkg::*;
#(
    parameter int                ADDR_W     = 24,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = 24'hFFFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] ptr,
    output logic              empty,
    output sdram_addr_t       fields
);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (adv) begin
            ptr_d = (ptr_q == ADDR_LIMIT) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr    = ptr_q;
    assign empty  = (ptr_q == wr_addr);
    assign fields = split_addr(ptr_q);

endmodule

// File: rtl/sdram_record_reader.sv
// Reads SDRAM words behind the writer and rebuilds Geiger/magnetometer records.
// Optional read timeout/reissue: define READBACK_TIMEOUT_EN.
module sdram_record_reader
    import sdram_pkg::*;
#(
    parameter int                ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT  = 24'hFFFFFF,
    parameter int                TIMEOUT_CYC = 255
) (
    input logic                   CLK_48MHZ,
    input logic                   RESET,
    sdram_record_reader_if.master bus
);

    rd_state_e   state_q;
    logic        rd_req_q;
    logic [2:0]  idx_q;
    logic [2:0]  len_q;
    logic [79:0] rec_data_q;
    rec_type_e   rec_type_q;
    logic        rec_valid_q;
    logic        err_tag_q;

    logic [ADDR_W-1:0] ptr;
    logic              empty;
    sdram_addr_t       fields;
    logic              adv;
    logic [3:0]        tag;
    logic [2:0]        slot;

    assign adv  = (state_q == ST_WAIT) && bus.RD_VALID;
    assign tag  = bus.RD_DATA[15:12];
    // First payload word goes to the most significant slot of the record.
    assign slot = len_q - idx_q;

    sdram_addr_ptr #(
        .ADDR_W     (ADDR_W),
        .ADDR_LIMIT (ADDR_LIMIT)
    ) u_ptr (
        .clk     (CLK_48MHZ),
        .rst     (RESET),
        .adv     (adv),
        .wr_addr (bus.WR_ADDR),
        .ptr     (ptr),
        .empty   (empty),
        .fields  (fields)
    );

`ifdef READBACK_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            err_to_q;
`endif

    always_ff @(posedge CLK_48MHZ or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            rd_req_q    <= 1'b0;
            idx_q       <= '0;
            len_q       <= '0;
            rec_data_q  <= '0;
            rec_type_q  <= REC_NONE;
            rec_valid_q <= 1'b0;
            err_tag_q   <= 1'b0;
`ifdef READBACK_TIMEOUT_EN
            to_cnt_q    <= '0;
            err_to_q    <= 1'b0;
`endif
        end else begin
            err_tag_q <= 1'b0;
`ifdef READBACK_TIMEOUT_EN
            err_to_q  <= 1'b0;
`endif
            unique case (state_q)
                ST_IDLE: begin
                    if (!empty) begin
                        state_q  <= ST_ISSUE;
                        rd_req_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (bus.RD_ACK) begin
                        rd_req_q <= 1'b0;
                        state_q  <= ST_WAIT;
`ifdef READBACK_TIMEOUT_EN
                        to_cnt_q <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (bus.RD_VALID) begin
                        state_q <= ST_IDLE;
                        if (idx_q == 3'd0) begin
                            unique case (1'b1)
                                (tag == TAG_GEIG): begin
                                    len_q      <= LEN_GEIG;
                                    rec_type_q <= REC_GEIG;
                                    rec_data_q <= '0;
                                    idx_q      <= 3'd1;
                                end
                                (tag == TAG_MAG): begin
                                    len_q      <= LEN_MAG;
                                    rec_type_q <= REC_MAG;
                                    rec_data_q <= '0;
                                    idx_q      <= 3'd1;
                                end
                                default: err_tag_q <= 1'b1;
                            endcase
                        end else begin
                            rec_data_q[{slot, 4'b0000} +: 16] <= bus.RD_DATA;
                            if (idx_q == len_q) begin
                                state_q     <= ST_PRESENT;
                                rec_valid_q <= 1'b1;
                            end else begin
                                idx_q <= idx_q + 3'd1;
                            end
                        end
                    end
`ifdef READBACK_TIMEOUT_EN
                    // Pointer untouched, so the reissue reads the same word.
                    else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                        err_to_q <= 1'b1;
                        to_cnt_q <= '0;
                        state_q  <= ST_ISSUE;
                        rd_req_q <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end
                ST_PRESENT: begin
                    if (bus.REC_READY) begin
                        rec_valid_q <= 1'b0;
                        idx_q       <= '0;
                        state_q     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.RD_REQ    = rd_req_q;
    assign bus.RD_ROW    = fields.row;
    assign bus.RD_BA     = fields.ba;
    assign bus.RD_COL    = fields.col;
    assign bus.RD_PTR    = ptr;
    assign bus.REC_DATA  = rec_data_q;
    assign bus.REC_TYPE  = rec_type_q;
    assign bus.REC_VALID = rec_valid_q;
    assign bus.ERR_TAG   = err_tag_q;
`ifdef READBACK_TIMEOUT_EN
    assign bus.ERR_TIMEOUT = err_to_q;
`else
    assign bus.ERR_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_record_reader.sv
// Bench for sdram_record_reader: SDRAM responder model, record monitor and
// a record-level reference model (list of expected records).
module tb_sdram_record_reader;

    localparam logic [23:0] LIMIT = 24'h0007FF;

    typedef struct {
        logic [1:0]  t;
        logic [79:0] d;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_record_reader_if bus ();

    sdram_record_reader #(
        .ADDR_W      (24),
        .ADDR_LIMIT  (LIMIT),
        .TIMEOUT_CYC (255)
    ) dut (
        .CLK_48MHZ (clk),
        .RESET     (rst),
        .bus       (bus)
    );

    int vec = 0;
    int errs = 0;
    logic [15:0] mem [0:2047];
    logic [23:0] wp = '0;
    rec_t got_q[$];
    rec_t exp_q[$];
    logic [23:0] issued_q[$];
    int tag_cnt = 0, to_cnt = 0, unstable = 0, req_in_present = 0, exp_tag = 0;
    bit withhold = 0, noise_en = 0, rdy_rand = 0, rdy_fix = 0, stall_rand = 0;

    // SDRAM interface model: random ack delay and read latency, spurious
    // RD_VALID outside the read window and in the ack cycle.
    initial begin
        logic [23:0] a;
        bus.RD_ACK = 1'b0;
        bus.RD_VALID = 1'b0;
        bus.RD_DATA = '0;
        forever begin
            @(negedge clk);
            bus.RD_VALID = 1'b0;
            if (bus.RD_REQ && !rst) begin
                a = {bus.RD_ROW, bus.RD_BA, bus.RD_COL};
                issued_q.push_back(a);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                bus.RD_ACK = 1'b1;
                if (noise_en && $urandom_range(0, 2) == 0) begin
                    bus.RD_VALID = 1'b1;
                    bus.RD_DATA = 16'h2FFF;
                end
                @(negedge clk);
                bus.RD_ACK = 1'b0;
                bus.RD_VALID = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                if (!withhold) begin
                    bus.RD_VALID = 1'b1;
                    bus.RD_DATA = mem[a[10:0]];
                    @(negedge clk);
                    bus.RD_VALID = 1'b0;
                end
            end else if (noise_en && !rst && $urandom_range(0, 7) == 0) begin
                bus.RD_VALID = 1'b1;
                bus.RD_DATA = 16'h1ABC;
            end
        end
    end

    initial begin
        bus.REC_READY = 1'b0;
        forever begin
            @(negedge clk);
            bus.REC_READY = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fix;
        end
    end

    // Collects accepted records and error pulses; flags REC_* changing while held.
    initial begin
        rec_t cur;
        bit in_rec;
        in_rec = 0;
        forever begin
            @(negedge clk);
            #1;
            if (bus.REC_VALID) begin
                if (!in_rec) begin
                    cur.t = bus.REC_TYPE;
                    cur.d = bus.REC_DATA;
                    in_rec = 1;
                end else if (bus.REC_TYPE !== cur.t || bus.REC_DATA !== cur.d) begin
                    unstable++;
                end
                if (bus.RD_REQ) req_in_present++;
                if (bus.REC_READY) begin
                    got_q.push_back(cur);
                    in_rec = 0;
                end
            end else begin
                in_rec = 0;
            end
            if (bus.ERR_TAG) tag_cnt++;
            if (bus.ERR_TIMEOUT) to_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_word(input logic [15:0] w);
        mem[wp[10:0]] = w;
        wp = (wp == LIMIT) ? 24'd0 : wp + 24'd1;
        if (stall_rand && $urandom_range(0, 7) == 0) begin
            bus.WR_ADDR = wp;
            tick($urandom_range(0, 6));
        end
    endtask

    task automatic put_rec(input bit mag);
        rec_t r;
        logic [15:0] w;
        r.d = '0;
        r.t = mag ? 2'b10 : 2'b01;
        put_word({mag ? 4'h2 : 4'h1, 12'($urandom)});
        for (int i = 0; i < (mag ? 5 : 3); i++) begin
            w = 16'($urandom);
            put_word(w);
            r.d = {r.d[63:0], w};
        end
        exp_q.push_back(r);
    endtask

    task automatic wait_recs(input int n, input int budget, output bit ok);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            @(negedge clk);
            #2;
            k++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic wait_ptr(input logic [23:0] p, input int budget, output bit ok);
        int k = 0;
        while (bus.RD_PTR !== p && k < budget) begin
            @(negedge clk);
            #2;
            k++;
        end
        ok = (bus.RD_PTR === p);
    endtask

    task automatic test_reset;
        bus.WR_ADDR = '0;
        rst = 1'b1;
        tick(3);
        vec++; if (bus.RD_REQ !== 1'b0) begin errs++; $display("FAIL rst_req: got %b want 0", bus.RD_REQ); end
        vec++; if (bus.RD_PTR !== 24'd0) begin errs++; $display("FAIL rst_ptr: got %h want 0", bus.RD_PTR); end
        vec++; if ({bus.RD_ROW, bus.RD_BA, bus.RD_COL} !== 24'd0) begin errs++; $display("FAIL rst_addr: got %h want 0", {bus.RD_ROW, bus.RD_BA, bus.RD_COL}); end
        vec++; if (bus.REC_VALID !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", bus.REC_VALID); end
        vec++; if (bus.REC_DATA !== 80'd0) begin errs++; $display("FAIL rst_data: got %h want 0", bus.REC_DATA); end
        vec++; if (bus.REC_TYPE !== 2'b00) begin errs++; $display("FAIL rst_type: got %b want 00", bus.REC_TYPE); end
        vec++; if ({bus.ERR_TAG, bus.ERR_TIMEOUT} !== 2'b00) begin errs++; $display("FAIL rst_err: got %b want 00", {bus.ERR_TAG, bus.ERR_TIMEOUT}); end
        rst = 1'b0;
        tick(5);
        vec++; if (bus.RD_REQ !== 1'b0) begin errs++; $display("FAIL empty_idle: got req %b want 0", bus.RD_REQ); end
    endtask

    task automatic test_geiger;
        bit ok;
        got_q.delete();
        rdy_fix = 1;
        put_word(16'h1000); put_word(16'hAAAA); put_word(16'hBBBB); put_word(16'hCCCC);
        bus.WR_ADDR = wp;
        wait_recs(1, 200, ok);
        vec++;
        if (!ok) begin
            errs++; $display("FAIL geig_wait: got %0d records want 1", got_q.size());
        end else begin
            vec++; if (got_q[0].t !== 2'b01) begin errs++; $display("FAIL geig_type: got %b want 01", got_q[0].t); end
            vec++; if (got_q[0].d !== 80'h0000_0000_AAAA_BBBB_CCCC) begin errs++; $display("FAIL geig_data: got %h want 0000_0000_aaaa_bbbb_cccc", got_q[0].d); end
        end
        tick(5);
        vec++; if (got_q.size() != 1) begin errs++; $display("FAIL geig_once: got %0d records want 1", got_q.size()); end
        vec++; if (bus.RD_PTR !== 24'd4) begin errs++; $display("FAIL geig_ptr: got %h want 4", bus.RD_PTR); end
        vec++; if ({bus.RD_REQ, bus.REC_VALID} !== 2'b00) begin errs++; $display("FAIL geig_idle: got req/valid %b want 00", {bus.RD_REQ, bus.REC_VALID}); end
    endtask

    task automatic test_mag_backpressure;
        bit ok;
        int k = 0;
        rdy_fix = 0;
        tick(2);
        got_q.delete();
        unstable = 0;
        req_in_present = 0;
        put_word(16'h2000);
        for (int i = 1; i <= 5; i++) put_word(16'(i));
        bus.WR_ADDR = wp;
        while (bus.REC_VALID !== 1'b1 && k < 300) begin @(negedge clk); #2; k++; end
        vec++; if (bus.REC_VALID !== 1'b1) begin errs++; $display("FAIL mag_wait: got valid %b want 1", bus.REC_VALID); end
        tick(10);
        vec++; if (bus.REC_VALID !== 1'b1) begin errs++; $display("FAIL mag_hold: got valid %b want 1", bus.REC_VALID); end
        vec++; if (bus.REC_DATA !== 80'h0001_0002_0003_0004_0005) begin errs++; $display("FAIL mag_held_data: got %h want 0001_0002_0003_0004_0005", bus.REC_DATA); end
        rdy_fix = 1;
        wait_recs(1, 20, ok);
        vec++;
        if (!ok) begin
            errs++; $display("FAIL mag_accept: got %0d records want 1", got_q.size());
        end else begin
            vec++; if (got_q[0].t !== 2'b10 || got_q[0].d !== 80'h0001_0002_0003_0004_0005) begin errs++; $display("FAIL mag_rec: got %b/%h want 10/0001_0002_0003_0004_0005", got_q[0].t, got_q[0].d); end
        end
        vec++; if (unstable != 0) begin errs++; $display("FAIL mag_stable: got %0d changes want 0", unstable); end
        vec++; if (req_in_present != 0) begin errs++; $display("FAIL mag_no_req: got %0d req cycles want 0", req_in_present); end
    endtask

    task automatic test_bad_tag;
        bit ok;
        got_q.delete();
        tag_cnt = 0;
        put_word(16'h7000);
        put_word(16'h1000); put_word(16'h1111); put_word(16'h2222); put_word(16'h3333);
        bus.WR_ADDR = wp;
        wait_recs(1, 300, ok);
        vec++; if (tag_cnt != 1) begin errs++; $display("FAIL tag_pulse: got %0d pulses want 1", tag_cnt); end
        vec++;
        if (!ok) begin
            errs++; $display("FAIL tag_rec_wait: got %0d records want 1", got_q.size());
        end else if (got_q[0].t !== 2'b01 || got_q[0].d !== 80'h0000_0000_1111_2222_3333) begin
            errs++; $display("FAIL tag_rec: got %b/%h want 01/0000_0000_1111_2222_3333", got_q[0].t, got_q[0].d);
        end
    endtask

    task automatic test_random;
        bit ok;
        logic [3:0] bt;
        got_q.delete();
        exp_q.delete();
        tag_cnt = 0;
        exp_tag = 0;
        unstable = 0;
        req_in_present = 0;
        rdy_rand = 1; noise_en = 1; stall_rand = 1;
        while (wp < LIMIT - 24'd12) begin
            if ($urandom_range(0, 7) == 0) begin
                bt = 4'($urandom_range(3, 16));
                put_word({bt, 12'($urandom)});
                exp_tag++;
            end else begin
                put_rec($urandom_range(0, 1) == 1);
            end
            if ($urandom_range(0, 1) == 0) begin
                bus.WR_ADDR = wp;
                tick($urandom_range(0, 15));
            end
        end
        bus.WR_ADDR = wp;
        stall_rand = 0;
        wait_recs(exp_q.size(), 40000, ok);
        vec++; if (!ok) begin errs++; $display("FAIL rand_count: got %0d records want %0d", got_q.size(), exp_q.size()); end
        wait_ptr(wp, 300, ok);
        vec++; if (!ok) begin errs++; $display("FAIL rand_ptr: got %h want %h", bus.RD_PTR, wp); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vec++;
            if (got_q[i].t !== exp_q[i].t || got_q[i].d !== exp_q[i].d)
            begin
                errs++;
                $display("FAIL rand_rec%0d: got %b/%h want %b/%h", i, got_q[i].t, got_q[i].d, exp_q[i].t, exp_q[i].d);
            end
        end
        tick(4);
        vec++; if (tag_cnt != exp_tag) begin errs++; $display("FAIL rand_tags: got %0d want %0d", tag_cnt, exp_tag); end
        vec++; if (unstable != 0) begin errs++; $display("FAIL rand_stable: got %0d want 0", unstable); end
        vec++; if (req_in_present != 0) begin errs++; $display("FAIL rand_no_req: got %0d want 0", req_in_present); end
        rdy_rand = 0; noise_en = 0; rdy_fix = 1;
    endtask

    task automatic test_wrap;
        bit ok;
        int pads = 0;
        got_q.delete();
        tag_cnt = 0;
        while (wp != LIMIT - 24'd1) begin
            put_word(16'h0000);
            pads++;
        end
        put_word(16'h2000);
        put_word(16'hA001); put_word(16'hA002); put_word(16'hA003);
        put_word(16'hA004); put_word(16'hA005);
        bus.WR_ADDR = 24'd2;
        wait_ptr(24'd2, 2000, ok);
        vec++; if (!ok) begin errs++; $display("FAIL wrap_ptr: got %h want 2", bus.RD_PTR); end
        tick(20);
        vec++; if (got_q.size() != 0) begin errs++; $display("FAIL wrap_stall_rec: got %0d records want 0", got_q.size()); end
        vec++; if (bus.RD_REQ !== 1'b0) begin errs++; $display("FAIL wrap_stall_req: got %b want 0", bus.RD_REQ); end
        vec++; if (issued_q[$-2] !== LIMIT) begin errs++; $display("FAIL wrap_last: got %h want %h", issued_q[$-2], LIMIT); end
        vec++; if (issued_q[$-1] !== 24'd0) begin errs++; $display("FAIL wrap_zero: got %h want 0", issued_q[$-1]); end
        vec++; if (issued_q[$] !== 24'd1) begin errs++; $display("FAIL wrap_one: got %h want 1", issued_q[$]); end
        bus.WR_ADDR = wp;
        wait_recs(1, 300, ok);
        vec++;
        if (!ok) begin
            errs++; $display("FAIL wrap_rec_wait: got %0d records want 1", got_q.size());
        end else if (got_q[0].t !== 2'b10 || got_q[0].d !== 80'hA001_A002_A003_A004_A005) begin
            errs++; $display("FAIL wrap_rec: got %b/%h want 10/a001_a002_a003_a004_a005", got_q[0].t, got_q[0].d);
        end
        vec++; if (tag_cnt != pads) begin errs++; $display("FAIL wrap_pads: got %0d want %0d", tag_cnt, pads); end
        vec++; if (bus.RD_PTR !== 24'd4) begin errs++; $display("FAIL wrap_end_ptr: got %h want 4", bus.RD_PTR); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        got_q.delete();
        put_word(16'h1000); put_word(16'h5A5A); put_word(16'hA5A5);
        bus.WR_ADDR = wp;
        wait_ptr(wp, 300, ok);
        vec++; if (!ok) begin errs++; $display("FAIL mid_ptr: got %h want %h", bus.RD_PTR, wp); end
        tick(5);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        vec++; if (bus.RD_PTR !== 24'd0) begin errs++; $display("FAIL mid_rst_ptr: got %h want 0", bus.RD_PTR); end
        vec++; if ({bus.RD_REQ, bus.REC_VALID, bus.ERR_TAG, bus.ERR_TIMEOUT} !== 4'b0000) begin errs++; $display("FAIL mid_rst_ctl: got %b want 0000", {bus.RD_REQ, bus.REC_VALID, bus.ERR_TAG, bus.ERR_TIMEOUT}); end
        vec++; if ({bus.REC_DATA, bus.REC_TYPE, bus.RD_ROW, bus.RD_BA, bus.RD_COL} !== 106'd0) begin errs++; $display("FAIL mid_rst_data: got %h want 0", {bus.REC_DATA, bus.REC_TYPE}); end
        bus.WR_ADDR = '0;
        tick(2);
        rst = 1'b0;
        tick(20);
        vec++; if (got_q.size() != 0) begin errs++; $display("FAIL mid_no_rec: got %0d records want 0", got_q.size()); end
        wp = '0;
        put_word(16'h1000); put_word(16'hDEAD); put_word(16'hBEEF); put_word(16'h0123);
        bus.WR_ADDR = wp;
        wait_recs(1, 300, ok);
        vec++;
        if (!ok) begin
            errs++; $display("FAIL mid_recover_wait: got %0d records want 1", got_q.size());
        end else if (got_q[0].t !== 2'b01 || got_q[0].d !== 80'h0000_0000_DEAD_BEEF_0123) begin
            errs++; $display("FAIL mid_recover: got %b/%h want 01/0000_0000_dead_beef_0123", got_q[0].t, got_q[0].d);
        end
    endtask

`ifdef READBACK_TIMEOUT_EN
    task automatic test_timeout;
        bit ok;
        int k = 0;
        int n0;
        got_q.delete();
        to_cnt = 0;
        withhold = 1;
        put_word(16'h1000); put_word(16'h4444); put_word(16'h5555); put_word(16'h6666);
        n0 = issued_q.size();
        bus.WR_ADDR = 24'd5;
        while (to_cnt == 0 && k < 400) begin @(negedge clk); #2; k++; end
        vec++; if (to_cnt != 1) begin errs++; $display("FAIL to_pulse: got %0d pulses want 1", to_cnt); end
        vec++; if (k < 250 || k > 265) begin errs++; $display("FAIL to_delay: got %0d cycles want 250..265", k); end
        tick(5);
        vec++; if (issued_q.size() != n0 + 2) begin errs++; $display("FAIL to_reissue: got %0d issues want %0d", issued_q.size() - n0, 2); end
        vec++; if (issued_q[$] !== 24'd4 || issued_q[$-1] !== 24'd4) begin errs++; $display("FAIL to_addr: got %h/%h want 4/4", issued_q[$-1], issued_q[$]); end
        vec++; if (bus.RD_PTR !== 24'd4) begin errs++; $display("FAIL to_ptr: got %h want 4", bus.RD_PTR); end
        withhold = 0;
        bus.WR_ADDR = wp;
        wait_recs(1, 800, ok);
        vec++;
        if (!ok) begin
            errs++; $display("FAIL to_rec_wait: got %0d records want 1", got_q.size());
        end else if (got_q[0].d !== 80'h0000_0000_4444_5555_6666) begin
            errs++; $display("FAIL to_rec: got %h want 0000_0000_4444_5555_6666", got_q[0].d);
        end
    endtask
`else
    task automatic test_no_timeout;
        vec++; if (to_cnt != 0) begin errs++; $display("FAIL no_timeout: got %0d pulses want 0", to_cnt); end
    endtask
`endif

    initial begin
        bus.WR_ADDR = '0;
        test_reset();
        test_geiger();
        test_mag_backpressure();
        test_bad_tag();
        test_random();
        test_wrap();
        test_reset_mid();
`ifdef READBACK_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
